// File: rtl/ni_packetizer_if.sv
// ni_packetizer_if: the core-side request/payload handshake, the router port-4 flit interface
// and the status outputs of the packetizer, bundled as one interface.
// Ports: slave = packetizer view (drives flits, ready and status); master = core/router view.
interface ni_packetizer_if #(
  parameter int ARRAYW = 1,
  parameter int DATAW  = 34,
  parameter int VCH    = 1,
  parameter int VCHW   = 0
);
  logic [ARRAYW:0] my_xpos;
  logic [ARRAYW:0] my_ypos;
  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_dst;
  logic [2:0]      req_len;
  logic            pld_valid;
  logic            pld_ready;
  logic [21:0]     pld_data;
  logic [DATAW:0]  odata;
  logic            ovalid;
  logic [VCHW:0]   ovch;
  logic [VCH:0]    irdy;
  logic [VCH:0]    iack;
  logic [VCH:0]    ilck;
  logic            busy;
  logic            drained;
  logic            pkt_done;

  modport slave (
    input  my_xpos, my_ypos, req_valid, req_dst, req_len, pld_valid, pld_data,
    input  irdy, iack, ilck,
    output req_ready, pld_ready, odata, ovalid, ovch, busy, drained, pkt_done
  );

  modport master (
    output my_xpos, my_ypos, req_valid, req_dst, req_len, pld_valid, pld_data,
    output irdy, iack, ilck,
    input  req_ready, pld_ready, odata, ovalid, ovch, busy, drained, pkt_done
  );
endinterface

// File: rtl/ni_packetizer.sv
// ni_packetizer: turns core packet requests plus payload words into HEAD/DATA/TAIL flits for router port 4.
// Latency: first flit valid 4 cycles after a request push into an empty idle stage; at most 1 flit per 2 cycles.
// Backpressure: a flit is held stable until irdy[ovch]; req_ready = FIFO not full; payload consumed only in LOAD.
// Ports: clk, rst_ (async, active-low), bus (ni_packetizer_if.slave): request/payload from the core,
//   odata/ovalid/ovch to the router, irdy/iack/ilck from the router, busy/drained/pkt_done status.
`ifndef TYPE_HEAD
`define TYPE_HEAD 3'b001
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 3'b010
`endif
`ifndef TYPE_DATA
`define TYPE_DATA 3'b100
`endif

module ni_packetizer #(
  parameter int REQ_DEPTH = 4,
  parameter int PEND_W    = 4
) (
  input  logic           clk,
  input  logic           rst_,
  ni_packetizer_if.slave bus
);
  localparam int AW = $clog2(REQ_DEPTH);

  typedef enum logic [1:0] {IDLE, VCSEL, LOAD, SEND} state_t;

  state_t            r_state, w_state_nxt;
  logic [6:0]        r_fifo [REQ_DEPTH];
  logic [AW:0]       r_wptr, r_rptr;
  logic [3:0]        r_dst;
  logic [2:0]        r_len;
  logic              r_vc;
  logic [3:0]        r_idx;
  logic [34:0]       r_odata;
  logic              r_ovalid;
  logic              r_pkt_done;
  logic [PEND_W-1:0] r_pend;

  logic              w_empty, w_full, w_push, w_pop;
  logic              w_vc_ld, w_vc_sel, w_load, w_accept, w_pld_ready, w_is_tail;
  logic [2:0]        w_ftype;
  logic [PEND_W:0]   w_sum, w_acks, w_diff;
  logic [PEND_W-1:0] w_pend_nxt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = bus.req_valid && !w_full;

  assign w_is_tail = (r_idx == ({1'b0, r_len} + 4'd1));
  assign w_ftype   = (r_idx == 4'd0) ? `TYPE_HEAD : (w_is_tail ? `TYPE_TAIL : `TYPE_DATA);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_vc_ld     = 1'b0;
    w_vc_sel    = 1'b0;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    w_pld_ready = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = VCSEL;
        end
      end
      VCSEL: begin
        // Lowest unlocked VC wins; with both locked we simply retry next cycle.
        if (!bus.ilck[0]) begin
          w_vc_ld     = 1'b1;
          w_state_nxt = LOAD;
        end else if (!bus.ilck[1]) begin
          w_vc_ld     = 1'b1;
          w_vc_sel    = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_pld_ready = bus.pld_valid;
        if (bus.pld_valid) begin
          w_load      = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (r_ovalid && bus.irdy[r_vc]) begin
          w_accept    = 1'b1;
          w_state_nxt = w_is_tail ? IDLE : LOAD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outstanding flits: add this cycle's accept, remove this cycle's acks, clamp to [0, 2^PEND_W-1].
  always_comb begin
    w_acks = '0;
    for (int i = 0; i < $bits(bus.iack); i++) begin
      w_acks = w_acks + (PEND_W+1)'(bus.iack[i]);
    end
    w_sum  = {1'b0, r_pend} + (PEND_W+1)'(w_accept);
    w_diff = w_sum - w_acks;
    if (w_sum < w_acks)    w_pend_nxt = '0;
    else if (w_diff[PEND_W]) w_pend_nxt = '1;
    else                     w_pend_nxt = w_diff[PEND_W-1:0];
  end

  // Request storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr[AW-1:0]] <= {bus.req_dst, bus.req_len};
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_dst      <= '0;
      r_len      <= '0;
      r_vc       <= 1'b0;
      r_idx      <= '0;
      r_odata    <= '0;
      r_ovalid   <= 1'b0;
      r_pkt_done <= 1'b0;
      r_pend     <= '0;
    end else begin
      r_pkt_done <= w_accept && w_is_tail;
      r_pend     <= w_pend_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        {r_dst, r_len} <= r_fifo[r_rptr[AW-1:0]];
      end
      if (w_vc_ld) begin
        r_vc  <= w_vc_sel;
        r_idx <= '0;
      end
      if (w_load) begin
        r_odata  <= {w_ftype, bus.pld_data, 1'b0, r_vc,
                     bus.my_xpos[1:0], bus.my_ypos[1:0], r_dst};
        r_ovalid <= 1'b1;
      end
      if (w_accept) begin
        r_ovalid <= 1'b0;
        r_idx    <= r_idx + 4'd1;
      end
    end
  end

  assign bus.req_ready = !w_full;
  assign bus.pld_ready = w_pld_ready;
  assign bus.odata     = r_odata;
  assign bus.ovalid    = r_ovalid;
  assign bus.ovch      = r_vc;
  assign bus.busy      = (r_state != IDLE);
  assign bus.drained   = (r_state == IDLE) && w_empty && (r_pend == '0);
  assign bus.pkt_done  = r_pkt_done;
endmodule

// File: tb/tb_ni_packetizer.sv
// tb_ni_packetizer: randomized and directed stimulus for ni_packetizer, checked against a
// packet-level reference model (request list, consumed-word list, outstanding-flit count).
module tb_ni_packetizer;
  localparam logic [2:0] T_HEAD = 3'b001;
  localparam logic [2:0] T_TAIL = 3'b010;
  localparam logic [2:0] T_DATA = 3'b100;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  initial begin
    #2;
    forever #5 clk = ~clk;
  end

  ni_packetizer_if bus ();
  ni_packetizer #(.REQ_DEPTH(4), .PEND_W(4)) dut (.clk(clk), .rst_(rst_), .bus(bus.slave));

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [6:0]  q_req[$];    // {dst,len} of requests taken but whose TAIL is not yet accepted
  logic [21:0] q_cons[$];   // payload words consumed, not yet seen in an accepted flit
  logic [21:0] q_words[$];  // preset payload words to present next
  logic [35:0] q_obs[$];    // accepted {ovch, odata}
  logic [35:0] q_exp[$];    // model's flit for each accept
  int   m_idx = 0, m_pend = 0, done_cnt = 0, acc_cnt = 0;
  logic exp_vc = 1'b0;
  logic mon_en = 1'b0;
  logic consumed_last = 1'b0;

  // Predicts what the next rising edge does and updates the model accordingly.
  task automatic monitor();
    logic       acc;
    logic [2:0] ft;
    logic [6:0] rq;
    logic [21:0] w;
    logic [35:0] e;
    int         n;
    if (bus.pkt_done) done_cnt++;
    if (bus.req_valid && bus.req_ready) q_req.push_back({bus.req_dst, bus.req_len});
    if (bus.pld_valid && bus.pld_ready) begin
      q_cons.push_back(bus.pld_data);
      consumed_last = 1'b1;
    end
    acc = bus.ovalid && bus.irdy[bus.ovch];
    if (acc) begin
      acc_cnt++;
      e = '1;
      if (q_req.size() > 0 && q_cons.size() > 0) begin
        rq = q_req[0];
        w  = q_cons.pop_front();
        ft = (m_idx == 0) ? T_HEAD : ((m_idx == int'(rq[2:0]) + 1) ? T_TAIL : T_DATA);
        e  = {exp_vc, ft, w, 1'b0, exp_vc, bus.my_xpos[1:0], bus.my_ypos[1:0], rq[6:3]};
        if (ft == T_TAIL) begin
          void'(q_req.pop_front());
          m_idx = 0;
        end else m_idx++;
      end
      q_obs.push_back({bus.ovch, bus.odata});
      q_exp.push_back(e);
    end
    n = m_pend + (acc ? 1 : 0) - int'(bus.iack[0]) - int'(bus.iack[1]);
    m_pend = (n < 0) ? 0 : ((n > 15) ? 15 : n);
  endtask

  task automatic tick();
    #1;
    if (mon_en) monitor();
    @(posedge clk);
    #1;
    if (consumed_last) begin
      consumed_last = 1'b0;
      if (q_words.size() > 0) bus.pld_data = q_words.pop_front();
      else bus.pld_data = 22'($urandom);
    end
  endtask

  task automatic push_req(input logic [3:0] dst, input logic [2:0] len);
    bus.req_valid = 1'b1;
    bus.req_dst   = dst;
    bus.req_len   = len;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget && done_cnt < n; i++) tick();
  endtask

  task automatic flush_acks();
    for (int i = 0; i < 20 && m_pend > 0; i++) begin
      bus.iack = 2'b11;
      tick();
    end
    bus.iack = 2'b00;
    tick();
  endtask

  task automatic new_test();
    q_obs.delete();
    q_exp.delete();
    done_cnt = 0;
    acc_cnt  = 0;
  endtask

  task automatic test_reset();
    bus.my_xpos = 2'd1; bus.my_ypos = 2'd1;
    bus.req_valid = 1'b0; bus.req_dst = '0; bus.req_len = '0;
    bus.pld_valid = 1'b1; bus.pld_data = '0;
    bus.irdy = 2'b11; bus.iack = 2'b00; bus.ilck = 2'b00;
    #12;
    vectors++; if (bus.ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got %b want 0", bus.ovalid); end
    vectors++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    vectors++; if (bus.drained !== 1'b1) begin errors++; $display("FAIL reset_drained got %b want 1", bus.drained); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.pld_ready !== 1'b0) begin errors++; $display("FAIL reset_pld_ready got %b want 0", bus.pld_ready); end
    vectors++; if (bus.pkt_done !== 1'b0) begin errors++; $display("FAIL reset_pkt_done got %b want 0", bus.pkt_done); end
    vectors++; if ({bus.ovch, bus.odata} !== 36'h0) begin errors++; $display("FAIL reset_odata got %h want 0", {bus.ovch, bus.odata}); end
    #3 rst_ = 1'b1;
    @(posedge clk); #1;
    vectors++; if (bus.ovalid !== 1'b0 || bus.busy !== 1'b0 || bus.drained !== 1'b1) begin
      errors++; $display("FAIL idle_after_reset got ovalid=%b busy=%b drained=%b want 0 0 1", bus.ovalid, bus.busy, bus.drained);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_minimal();
    new_test();
    bus.pld_data = 22'hA;
    q_words.push_back(22'hB);
    push_req(4'b0110, 3'd0);
    wait_done(1, 60);
    vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL minimal_pkt_done got %0d want 1", done_cnt); end
    vectors++; if (q_obs.size() !== 2) begin errors++; $display("FAIL minimal_flit_count got %0d want 2", q_obs.size()); end
    if (q_obs.size() == 2) begin
      vectors++; if (q_obs[0] !== {1'b0, T_HEAD, 22'hA, 2'b00, 4'b0101, 4'b0110}) begin
        errors++; $display("FAIL minimal_head got %h want %h", q_obs[0], {1'b0, T_HEAD, 22'hA, 2'b00, 4'b0101, 4'b0110}); end
      vectors++; if (q_obs[1] !== {1'b0, T_TAIL, 22'hB, 2'b00, 4'b0101, 4'b0110}) begin
        errors++; $display("FAIL minimal_tail got %h want %h", q_obs[1], {1'b0, T_TAIL, 22'hB, 2'b00, 4'b0101, 4'b0110}); end
    end
    tick();
    vectors++; if (bus.drained !== 1'b0) begin errors++; $display("FAIL minimal_unacked_drained got %b want 0", bus.drained); end
    bus.iack = 2'b01; tick();
    bus.iack = 2'b00; tick();
    bus.iack = 2'b01; tick();
    bus.iack = 2'b00; tick();
    vectors++; if (bus.drained !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL minimal_drained got drained=%b busy=%b want 1 0", bus.drained, bus.busy); end
  endtask

  task automatic test_backpressure();
    logic [34:0] held;
    new_test();
    bus.irdy = 2'b11;
    push_req(4'($urandom), 3'd1);
    for (int i = 0; i < 40 && acc_cnt < 1; i++) tick();
    bus.irdy = 2'b10;
    for (int i = 0; i < 10 && !bus.ovalid; i++) tick();
    held = bus.odata;
    vectors++; if (held[34:32] !== T_DATA) begin errors++; $display("FAIL bp_type got %b want %b", held[34:32], T_DATA); end
    for (int k = 0; k < 5; k++) begin
      vectors++; if (bus.ovalid !== 1'b1 || bus.odata !== held) begin
        errors++; $display("FAIL bp_hold cycle%0d got v=%b %h want v=1 %h", k, bus.ovalid, bus.odata, held); end
      if (k < 4) tick();
    end
    bus.irdy = 2'b11;
    tick();
    vectors++; if (acc_cnt !== 2 || bus.ovalid !== 1'b0) begin
      errors++; $display("FAIL bp_release got acc=%0d ovalid=%b want 2 0", acc_cnt, bus.ovalid); end
    wait_done(1, 40);
    vectors++; if (q_obs.size() !== 3) begin errors++; $display("FAIL bp_flit_count got %0d want 3", q_obs.size()); end
    for (int i = 0; i < q_obs.size(); i++) begin
      vectors++; if (q_obs[i] !== q_exp[i]) begin errors++; $display("FAIL bp_flit%0d got %h want %h", i, q_obs[i], q_exp[i]); end
    end
    flush_acks();
  endtask

  task automatic test_vc_lock();
    int nf;
    logic [2:0] len;
    new_test();
    bus.ilck = 2'b01; exp_vc = 1'b1;
    len = 3'($urandom);
    nf = int'(len) + 2;
    push_req(4'($urandom), len);
    wait_done(1, 80);
    bus.ilck = 2'b11; exp_vc = 1'b0;
    len = 3'($urandom);
    nf += int'(len) + 2;
    push_req(4'($urandom), len);
    for (int i = 0; i < 6; i++) tick();
    vectors++; if (bus.busy !== 1'b1 || bus.ovalid !== 1'b0 || bus.pld_ready !== 1'b0) begin
      errors++; $display("FAIL lock_wait got busy=%b ovalid=%b pld_ready=%b want 1 0 0", bus.busy, bus.ovalid, bus.pld_ready); end
    bus.ilck = 2'b10;
    for (int i = 0; i < 3; i++) tick();
    bus.ilck = 2'b01;  // VC0 locked after selection: packet must stay on VC0
    wait_done(2, 80);
    bus.ilck = 2'b00;
    vectors++; if (q_obs.size() !== nf) begin errors++; $display("FAIL lock_flit_count got %0d want %0d", q_obs.size(), nf); end
    for (int i = 0; i < q_obs.size(); i++) begin
      vectors++; if (q_obs[i] !== q_exp[i]) begin errors++; $display("FAIL lock_flit%0d got %h want %h", i, q_obs[i], q_exp[i]); end
    end
    flush_acks();
  endtask

  task automatic test_fifo_full();
    int nf = 0;
    logic [2:0] len;
    new_test();
    bus.irdy = 2'b00; exp_vc = 1'b0;
    // The first request is popped at once and stalls in SEND, so 4 more fill the FIFO.
    for (int k = 0; k < 5; k++) begin
      len = 3'($urandom);
      vectors++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_push%0d got %b want 1", k, bus.req_ready); end
      nf += int'(len) + 2;
      push_req(4'($urandom), len);
    end
    vectors++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", bus.req_ready); end
    push_req(4'($urandom), 3'($urandom));
    bus.irdy = 2'b11;
    wait_done(5, 400);
    for (int i = 0; i < 10; i++) tick();
    vectors++; if (done_cnt !== 5 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL full_packets got done=%0d busy=%b want 5 0", done_cnt, bus.busy); end
    vectors++; if (q_obs.size() !== nf) begin errors++; $display("FAIL full_flit_count got %0d want %0d", q_obs.size(), nf); end
    for (int i = 0; i < q_obs.size(); i++) begin
      vectors++; if (q_obs[i] !== q_exp[i]) begin errors++; $display("FAIL full_flit%0d got %h want %h", i, q_obs[i], q_exp[i]); end
    end
    flush_acks();
  endtask

  task automatic test_counter();
    new_test();
    bus.irdy = 2'b11;
    push_req(4'($urandom), 3'd1);
    wait_done(1, 60);
    tick();
    vectors++; if (bus.drained !== 1'b0) begin errors++; $display("FAIL cnt_three_drained got %b want 0", bus.drained); end
    bus.iack = 2'b11; tick();
    bus.iack = 2'b01; tick();
    bus.iack = 2'b00; tick();
    vectors++; if (bus.drained !== 1'b1) begin errors++; $display("FAIL cnt_zero_drained got %b want 1", bus.drained); end
    // 18 flits unacked saturate the count at 15; 8 double acks then clamp it to 0.
    push_req(4'($urandom), 3'd7);
    push_req(4'($urandom), 3'd7);
    wait_done(3, 120);
    for (int i = 0; i < 7; i++) begin
      bus.iack = 2'b11;
      tick();
    end
    bus.iack = 2'b00;
    vectors++; if (bus.drained !== 1'b0) begin errors++; $display("FAIL cnt_sat_pending got %b want 0", bus.drained); end
    bus.iack = 2'b11; tick();
    bus.iack = 2'b00;
    vectors++; if (bus.drained !== (m_pend == 0)) begin errors++; $display("FAIL cnt_sat_drained got %b want %b", bus.drained, (m_pend == 0)); end
    vectors++; if (q_obs.size() !== 21) begin errors++; $display("FAIL cnt_flit_count got %0d want 21", q_obs.size()); end
    for (int i = 0; i < q_obs.size(); i++) begin
      vectors++; if (q_obs[i] !== q_exp[i]) begin errors++; $display("FAIL cnt_flit%0d got %h want %h", i, q_obs[i], q_exp[i]); end
    end
  endtask

  task automatic test_random();
    logic [1:0] locks [3];
    int pushed, nf;
    locks[0] = 2'b00; locks[1] = 2'b01; locks[2] = 2'b10;
    for (int ph = 0; ph < 3; ph++) begin
      new_test();
      pushed = 0; nf = 0;
      bus.ilck = locks[ph];
      exp_vc = (locks[ph] == 2'b01);
      for (int c = 0; c < 2000 && done_cnt < 10; c++) begin
        bus.req_valid = (pushed < 10) && ($urandom % 3 == 0);
        bus.req_dst   = 4'($urandom);
        bus.req_len   = 3'($urandom);
        bus.pld_valid = ($urandom % 4 != 0);
        bus.irdy      = 2'($urandom);
        bus.iack      = ($urandom % 4 == 0) ? 2'($urandom) : 2'b00;
        if (bus.req_valid && bus.req_ready) begin
          pushed++;
          nf += int'(bus.req_len) + 2;
        end
        tick();
      end
      bus.req_valid = 1'b0; bus.pld_valid = 1'b1; bus.irdy = 2'b11; bus.iack = 2'b00;
      vectors++; if (done_cnt !== 10) begin errors++; $display("FAIL rand%0d_packets got %0d want 10", ph, done_cnt); end
      vectors++; if (q_obs.size() !== nf) begin errors++; $display("FAIL rand%0d_flit_count got %0d want %0d", ph, q_obs.size(), nf); end
      for (int i = 0; i < q_obs.size(); i++) begin
        vectors++; if (q_obs[i] !== q_exp[i]) begin errors++; $display("FAIL rand%0d_flit%0d got %h want %h", ph, i, q_obs[i], q_exp[i]); end
      end
      flush_acks();
      vectors++; if (bus.drained !== 1'b1) begin errors++; $display("FAIL rand%0d_drained got %b want 1", ph, bus.drained); end
    end
    bus.ilck = 2'b00; exp_vc = 1'b0;
  endtask

  task automatic test_midreset();
    new_test();
    bus.irdy = 2'b11; bus.pld_valid = 1'b1;
    push_req(4'($urandom), 3'd5);
    push_req(4'($urandom), 3'd2);
    push_req(4'($urandom), 3'd2);
    for (int i = 0; i < 40 && !(bus.ovalid && bus.odata[34:32] == T_DATA); i++) tick();
    vectors++; if (bus.ovalid !== 1'b1 || bus.odata[34:32] !== T_DATA) begin
      errors++; $display("FAIL mid_data_seen got v=%b type=%b want 1 %b", bus.ovalid, bus.odata[34:32], T_DATA); end
    rst_ = 1'b0;
    mon_en = 1'b0;
    #1;
    vectors++; if (bus.ovalid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.drained !== 1'b1) begin
      errors++; $display("FAIL mid_reset got ovalid=%b busy=%b req_ready=%b drained=%b want 0 0 1 1",
                         bus.ovalid, bus.busy, bus.req_ready, bus.drained); end
    q_req.delete(); q_cons.delete(); m_idx = 0; m_pend = 0; consumed_last = 1'b0;
    #10 rst_ = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    new_test();
    for (int i = 0; i < 15; i++) tick();
    vectors++; if (acc_cnt !== 0 || done_cnt !== 0 || bus.drained !== 1'b1) begin
      errors++; $display("FAIL mid_discard got acc=%0d done=%0d drained=%b want 0 0 1", acc_cnt, done_cnt, bus.drained); end
  endtask

  initial begin
    test_reset();
    test_minimal();
    test_backpressure();
    test_vc_lock();
    test_fifo_full();
    test_counter();
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
